// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants: reset/exception defaults, NOP encoding,
// 2-bit branch counter states and the IF/ID pipeline register layout.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hF000_0000;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        pred_taken;
    logic [31:0] pred_target;
  } if_id_t;

  // Saturating step of a 2-bit direction counter.
  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) r = (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       r = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory, hazard/redirect controls, BTB training and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface instruction_fetch_if;
  logic [31:0] ImemAddress;
  logic [31:0] ImemData;
  logic        Stall;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        ExceptionValid;
  logic        ResolveValid;
  logic [31:0] ResolvePC;
  logic        ResolveTaken;
  logic [31:0] ResolveTarget;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        IF_ID_PredTaken;
  logic [31:0] IF_ID_PredTarget;

  modport master (
    output ImemAddress, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_PredTaken, IF_ID_PredTarget,
    input  ImemData, Stall, RedirectValid, RedirectPC, ExceptionValid,
    input  ResolveValid, ResolvePC, ResolveTaken, ResolveTarget
  );

  modport slave (
    input  ImemAddress, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_PredTaken, IF_ID_PredTarget,
    output ImemData, Stall, RedirectValid, RedirectPC, ExceptionValid,
    output ResolveValid, ResolvePC, ResolveTaken, ResolveTarget
  );
endinterface

// File: rtl/instruction_fetch_branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational lookup,
// update at the clock edge so a same-cycle lookup sees the pre-update entry.
module branch_target_buffer
  import mips_fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  ctr_t               r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_up_hit, w_alloc;
  logic             w_unused_low_bits;

  assign w_lk_idx = i_lookup_pc[2 +: IDX_W];
  assign w_lk_tag = i_lookup_pc[31 -: TAG_W];
  assign w_up_idx = i_upd_pc[2 +: IDX_W];
  assign w_up_tag = i_upd_pc[31 -: TAG_W];
  assign w_unused_low_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_alloc  = i_upd_valid && !w_up_hit && i_upd_taken;

  assign o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_pred_target = r_target[w_lk_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (i_upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= ctr_update(r_ctr[w_up_idx], i_upd_taken);
        if (i_upd_taken) r_target[w_up_idx] <= i_upd_target;
      end else if (i_upd_taken) begin
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= i_upd_target;
        r_ctr[w_up_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Define BTB_EN to build the branch_target_buffer predictor; otherwise fetch always predicts PC+4.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  instruction_fetch_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  if_id_t      r_if_id;
  if_id_t      w_if_id_next;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef BTB_EN
  logic        w_btb_taken;
  logic [31:0] w_btb_target;

  branch_target_buffer #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (CLK),
    .rst          (Reset),
    .i_lookup_pc  (r_pc),
    .o_pred_taken (w_btb_taken),
    .o_pred_target(w_btb_target),
    .i_upd_valid  (bus.ResolveValid),
    .i_upd_pc     (bus.ResolvePC),
    .i_upd_taken  (bus.ResolveTaken),
    .i_upd_target (bus.ResolveTarget)
  );

  assign w_pred_taken  = w_btb_taken;
  assign w_pred_target = w_btb_taken ? w_btb_target : w_pc_plus4;
`else
  logic w_unused_resolve;

  assign w_unused_resolve = ^{bus.ResolveValid, bus.ResolvePC, bus.ResolveTaken,
                              bus.ResolveTarget, 32'(BTB_ENTRIES)};
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pc_plus4;
`endif

  always_comb begin
    w_next_pc    = w_pred_target;
    w_if_id_next = '{instr:       bus.ImemData,
                     pc_plus4:    w_pc_plus4,
                     valid:       1'b1,
                     pred_taken:  w_pred_taken,
                     pred_target: w_pred_target};
    if (bus.ExceptionValid || bus.RedirectValid) begin
      w_next_pc = bus.ExceptionValid ? EXC_VECTOR : {bus.RedirectPC[31:2], 2'b00};
      // Squash the slot; the stale PC+4/target fields are harmless once valid is low.
      w_if_id_next            = r_if_id;
      w_if_id_next.instr      = NOP_INSTR;
      w_if_id_next.valid      = 1'b0;
      w_if_id_next.pred_taken = 1'b0;
    end else if (bus.Stall) begin
      w_next_pc    = r_pc;
      w_if_id_next = r_if_id;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_if_id <= '0;
    end else begin
      r_pc    <= w_next_pc;
      r_if_id <= w_if_id_next;
    end
  end

  assign bus.ImemAddress      = r_pc;
  assign bus.IF_ID_Instr      = r_if_id.instr;
  assign bus.IF_ID_PCPlus4    = r_if_id.pc_plus4;
  assign bus.IF_ID_Valid      = r_if_id.valid;
  assign bus.IF_ID_PredTaken  = r_if_id.pred_taken;
  assign bus.IF_ID_PredTarget = r_if_id.pred_target;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected PC/IF_ID values are queued when each
// step is driven and popped after the clock edge that should produce them.
module tb_instruction_fetch;
  import mips_fetch_pkg::*;

`ifdef BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        pt;
    logic [31:0] ptgt;
  } exp_t;

  logic CLK;
  logic Reset;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] prog(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_0000: w = 32'h3408_0032;
      32'hF000_0000: w = 32'h8c08_0000;
      default:       w = {a[15:0], 16'hC0DE};
    endcase
    return w;
  endfunction

  always_comb bus.ImemData = prog(bus.ImemAddress);

  function automatic exp_t adv(input logic [31:0] pc);
    exp_t e;
    e = '{pc: pc + 32'd4, instr: prog(pc), pcp4: pc + 32'd4, valid: 1'b1, pt: 1'b0, ptgt: pc + 32'd4};
    return e;
  endfunction

  function automatic exp_t bubble(input logic [31:0] next_pc);
    exp_t e;
    e = '{pc: next_pc, instr: 32'h0, pcp4: 32'h0, valid: 1'b0, pt: 1'b0, ptgt: 32'h0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic stall, input logic rv, input logic [31:0] rpc,
                      input logic ev, input exp_t e);
    exp_t got;
    bus.Stall          = stall;
    bus.RedirectValid  = rv;
    bus.RedirectPC     = rpc;
    bus.ExceptionValid = ev;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    got = sb_q.pop_front();
    chk("pc", bus.ImemAddress, got.pc);
    chk("instr", bus.IF_ID_Instr, got.instr);
    chk("valid", 32'(bus.IF_ID_Valid), 32'(got.valid));
    chk("pred_taken", 32'(bus.IF_ID_PredTaken), 32'(got.pt));
    if (got.valid) begin
      chk("pcplus4", bus.IF_ID_PCPlus4, got.pcp4);
      chk("pred_target", bus.IF_ID_PredTarget, got.ptgt);
    end
    $display("step pc=%h instr=%h valid=%0d pt=%0d", bus.ImemAddress, bus.IF_ID_Instr,
             bus.IF_ID_Valid, bus.IF_ID_PredTaken);
    bus.ResolveValid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.ResolveValid  = 1'b1;
    bus.ResolvePC     = pc;
    bus.ResolveTaken  = taken;
    bus.ResolveTarget = tgt;
  endtask

  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b1;
    bus.Stall = 1'b0;
    bus.RedirectValid = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.ExceptionValid = 1'b0;
    bus.ResolveValid = 1'b0;
    bus.ResolvePC = 32'h0;
    bus.ResolveTaken = 1'b0;
    bus.ResolveTarget = 32'h0;

    #22;
    chk("rst_pc", bus.ImemAddress, 32'h0);
    chk("rst_instr", bus.IF_ID_Instr, 32'h0);
    chk("rst_pcplus4", bus.IF_ID_PCPlus4, 32'h0);
    chk("rst_valid", 32'(bus.IF_ID_Valid), 32'h0);
    chk("rst_pred_taken", 32'(bus.IF_ID_PredTaken), 32'h0);
    chk("rst_pred_target", bus.IF_ID_PredTarget, 32'h0);
    Reset = 1'b0;
    chk("cycle1_addr", bus.ImemAddress, 32'h0);

    // Sequential fetch from reset up to 0x10.
    for (int a = 0; a < 16; a += 4) step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'(a)));

    // Three stalled cycles at 0x10 hold PC and IF_ID, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, adv(32'hC));
    step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'h10));

    // Redirect to 0x188, then redirect with stall and misaligned target to 0x190.
    step(1'b0, 1'b1, 32'h188, 1'b0, bubble(32'h188));
    step(1'b1, 1'b1, 32'h193, 1'b0, bubble(32'h190));
    step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'h190));

    // Asynchronous reset mid-run.
    Reset = 1'b1;
    #1;
    chk("midrst_pc", bus.ImemAddress, 32'h0);
    chk("midrst_valid", 32'(bus.IF_ID_Valid), 32'h0);
    chk("midrst_instr", bus.IF_ID_Instr, 32'h0);
    Reset = 1'b0;

    // Exception outranks a simultaneous redirect.
    step(1'b0, 1'b1, 32'h44, 1'b1, bubble(32'hF000_0000));
    step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'hF000_0000));

    // PC+4 wraps at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, bubble(32'hFFFF_FFFC));
    step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'hFFFF_FFFC));

    // Branch at 0x51C: train taken twice, predict, then train not-taken twice.
    resolve(32'h51C, 1'b1, 32'h514);
    step(1'b0, 1'b1, 32'h51C, 1'b0, bubble(32'h51C));
    resolve(32'h51C, 1'b1, 32'h514);
    step(1'b0, 1'b1, 32'h51C, 1'b0, bubble(32'h51C));
    e = '{pc: BTB ? 32'h514 : 32'h520, instr: prog(32'h51C), pcp4: 32'h520, valid: 1'b1,
          pt: BTB, ptgt: BTB ? 32'h514 : 32'h520};
    step(1'b0, 1'b0, 32'h0, 1'b0, e);
    resolve(32'h51C, 1'b0, 32'h520);
    step(1'b0, 1'b1, 32'h51C, 1'b0, bubble(32'h51C));
    // Counter drops to weakly-taken; this lookup must still see it before the update lands.
    resolve(32'h51C, 1'b0, 32'h520);
    step(1'b0, 1'b0, 32'h0, 1'b0, e);
    step(1'b0, 1'b1, 32'h51C, 1'b0, bubble(32'h51C));
    step(1'b0, 1'b0, 32'h0, 1'b0, adv(32'h51C));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
